// File: rtl/pc_ras_unit.sv
// Program-counter unit with stall, beq/bne branch, absolute jump, and a
// circular return-address stack used by call (jal) and return (jr $ra).
module pc_ras_unit #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = {WIDTH{1'b0}},
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          branch,
    input  logic                          branch_ne,
    input  logic                          zero,
    input  logic [WIDTH-1:0]              branch_address,
    input  logic                          jump,
    input  logic [WIDTH-1:0]              jump_address,
    input  logic                          call,
    input  logic                          ret,
    output logic [WIDTH-1:0]              pc_out,
    output logic [WIDTH-1:0]              pc_plus4,
    output logic [$clog2(RAS_DEPTH):0]    ras_count,
    output logic                          ras_empty,
    output logic                          ras_full,
    output logic                          ras_underflow
);

    localparam int              PW       = $clog2(RAS_DEPTH);
    localparam int              CW       = PW + 1;
    localparam logic [PW-1:0]   PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_FULL = CW'(RAS_DEPTH);
    localparam logic [WIDTH-1:0] FOUR    = {{(WIDTH-3){1'b0}}, 3'b100};
    localparam logic [WIDTH-1:0] LOW_MASK = {{(WIDTH-2){1'b0}}, 2'b11};

    // Instruction targets are word-aligned; stray low bits are discarded.
    function automatic logic [WIDTH-1:0] align4(input logic [WIDTH-1:0] a);
        return a & ~LOW_MASK;
    endfunction

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             underflow_q, underflow_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [WIDTH-1:0] pc_plus4_s;
    logic [PW-1:0]    ptr_inc_s;
    logic             branch_taken_s;

    assign pc_plus4_s     = pc_q + FOUR;
    assign ptr_inc_s      = ptr_q + PTR_ONE;
    assign branch_taken_s = branch & (branch_ne ? ~zero : zero);

    // Next-PC selection and RAS update; ret outranks jump, jump outranks branch.
    always_comb begin
        pc_d        = pc_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        underflow_d = underflow_q;
        ras_d       = ras_q;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (count_q != CNT_ZERO) begin
                pc_d    = align4(ras_q[ptr_q]);
                ptr_d   = ptr_q - PTR_ONE;
                count_d = count_q - CNT_ONE;
            end else begin
                pc_d        = pc_plus4_s;
                underflow_d = 1'b1;
            end
        end else if (jump) begin
            pc_d = align4(jump_address);
            if (call) begin
                // When full the oldest entry is overwritten; depth saturates.
                ras_d[ptr_inc_s] = pc_plus4_s;
                ptr_d            = ptr_inc_s;
                if (count_q != CNT_FULL) begin
                    count_d = count_q + CNT_ONE;
                end else begin
                    count_d = count_q;
                end
            end else begin
                ptr_d = ptr_q;
            end
        end else if (branch_taken_s) begin
            pc_d = align4(branch_address);
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // PC, stack pointer, depth counter and sticky underflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_VECTOR;
            ptr_q       <= {PW{1'b0}};
            count_q     <= CNT_ZERO;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            underflow_q <= underflow_d;
        end
    end

    // Return-address storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    assign pc_out        = pc_q;
    assign pc_plus4      = pc_plus4_s;
    assign ras_count     = count_q;
    assign ras_empty     = (count_q == CNT_ZERO);
    assign ras_full      = (count_q == CNT_FULL);
    assign ras_underflow = underflow_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: the driver queues hand-computed expectations,
// a monitor pops and compares one per clock after the edge.
module tb_pc_ras_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, branch, branch_ne, zero, jump, call, ret;
    logic [31:0] branch_address, jump_address;
    logic [31:0] pc_out, pc_plus4;
    logic [2:0]  ras_count;
    logic        ras_empty, ras_full, ras_underflow;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] p4;
        logic [2:0]  cnt;
        logic        emp;
        logic        ful;
        logic        uf;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    pc_ras_unit #(
        .WIDTH(32), .RESET_VECTOR(32'h0040_0000), .RAS_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch),
        .branch_ne(branch_ne), .zero(zero), .branch_address(branch_address),
        .jump(jump), .jump_address(jump_address), .call(call), .ret(ret),
        .pc_out(pc_out), .pc_plus4(pc_plus4), .ras_count(ras_count),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(string name, logic [31:0] pc, logic [2:0] cnt, logic uf);
        exp_t e;
        e.name = name;
        e.pc   = pc;
        e.p4   = pc + 32'd4;
        e.cnt  = cnt;
        e.emp  = (cnt == 3'd0);
        e.ful  = (cnt == 3'd4);
        e.uf   = uf;
        return e;
    endfunction

    task automatic compare(input exp_t e);
        vectors++;
        if (pc_out !== e.pc || pc_plus4 !== e.p4 || ras_count !== e.cnt ||
            ras_empty !== e.emp || ras_full !== e.ful || ras_underflow !== e.uf) begin
            miscompares++;
            $display("FAIL %s: got pc=%h p4=%h cnt=%0d emp=%b full=%b uf=%b, expected pc=%h p4=%h cnt=%0d emp=%b full=%b uf=%b",
                     e.name, pc_out, pc_plus4, ras_count, ras_empty, ras_full, ras_underflow,
                     e.pc, e.p4, e.cnt, e.emp, e.ful, e.uf);
        end
    endtask

    // Monitor: one expectation per clock, checked just after the edge.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) compare(sb.pop_front());
    end

    task automatic clr();
        stall = 1'b0; branch = 1'b0; branch_ne = 1'b0; zero = 1'b0;
        jump = 1'b0; call = 1'b0; ret = 1'b0;
        branch_address = 32'h0; jump_address = 32'h0;
    endtask

    task automatic step(input string name, input logic [31:0] pc,
                        input logic [2:0] cnt, input logic uf);
        sb.push_back(mk(name, pc, cnt, uf));
        @(negedge clk);
        clr();
    endtask

    initial begin
        clr();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compare(mk("reset_state", 32'h0040_0000, 3'd0, 1'b0));
        reset = 1'b0;
        step("idle1", 32'h0040_0004, 3'd0, 1'b0);
        step("idle2", 32'h0040_0008, 3'd0, 1'b0);
        step("idle3", 32'h0040_000C, 3'd0, 1'b0);

        #2 reset = 1'b1;
        #1 compare(mk("async_reset", 32'h0040_0000, 3'd0, 1'b0));
        @(negedge clk);
        reset = 1'b0;

        branch = 1'b1; branch_address = 32'h10;
        step("beq_not_taken", 32'h0040_0004, 3'd0, 1'b0);
        branch = 1'b1; zero = 1'b1; branch_address = 32'h10;
        step("beq_taken", 32'h10, 3'd0, 1'b0);
        branch = 1'b1; branch_ne = 1'b1; branch_address = 32'h20;
        step("bne_taken", 32'h20, 3'd0, 1'b0);
        branch = 1'b1; branch_ne = 1'b1; branch_address = 32'h23;
        step("branch_align", 32'h20, 3'd0, 1'b0);
        branch = 1'b1; branch_ne = 1'b1; zero = 1'b1; branch_address = 32'h80;
        step("bne_not_taken", 32'h24, 3'd0, 1'b0);
        call = 1'b1;
        step("call_no_jump", 32'h28, 3'd0, 1'b0);
        jump = 1'b1; jump_address = 32'h102;
        step("jump_align", 32'h100, 3'd0, 1'b0);

        jump = 1'b1; call = 1'b1; jump_address = 32'h800;
        step("jal", 32'h800, 3'd1, 1'b0);
        ret = 1'b1;
        step("jr_ra", 32'h104, 3'd0, 1'b0);

        jump = 1'b1; jump_address = 32'h100;
        step("goto_100", 32'h100, 3'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            jump = 1'b1; call = 1'b1; jump_address = (i + 1) * 32'h100;
            step($sformatf("call%0d", i), (i + 1) * 32'h100, (i < 4) ? 3'(i) : 3'd4, 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            ret = 1'b1;
            step($sformatf("ret%0d", i + 1), 32'h504 - i * 32'h100, 3'(3 - i), 1'b0);
        end
        ret = 1'b1;
        step("ret_underflow", 32'h208, 3'd0, 1'b1);
        step("underflow_sticky", 32'h20C, 3'd0, 1'b1);

        for (int i = 0; i < 3; i++) begin
            stall = 1'b1; jump = 1'b1; ret = 1'b1; call = 1'b1; jump_address = 32'h900;
            step($sformatf("stall%0d", i + 1), 32'h20C, 3'd0, 1'b1);
        end
        jump = 1'b1; jump_address = 32'h900;
        step("stall_release", 32'h900, 3'd0, 1'b1);

        jump = 1'b1; jump_address = 32'h200;
        step("goto_200", 32'h200, 3'd0, 1'b1);
        jump = 1'b1; call = 1'b1; jump_address = 32'h700;
        step("call_from_200", 32'h700, 3'd1, 1'b1);
        stall = 1'b1; ret = 1'b1;
        step("stall_ret_held", 32'h700, 3'd1, 1'b1);
        ret = 1'b1; jump = 1'b1; call = 1'b1; jump_address = 32'hA00;
        step("ret_wins", 32'h204, 3'd0, 1'b1);

        jump = 1'b1; jump_address = 32'hFFFF_FFFC;
        step("goto_top", 32'hFFFF_FFFC, 3'd0, 1'b1);
        step("pc_wrap", 32'h0, 3'd0, 1'b1);
        step("after_wrap", 32'h4, 3'd0, 1'b1);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised program-counter unit for the MIPS core. It is the successor of the basic PC register.
- It adds a configurable PC width and reset vector, a pipeline stall input, a selectable branch condition (beq/bne) and an absolute jump path.
- It also adds a hardware return-address stack (RAS) that supports call/return (jal/jr $ra).
- It sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
- WIDTH, 32: PC and address width in bits (minimum 8).
- RESET_VECTOR, 0: value loaded into pc_out on reset. Must be 4-byte aligned.
- RAS_DEPTH, 4: number of return-address stack entries (minimum 2, power of two).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  hold PC and RAS; all other controls are ignored.
- branch  in  1  conditional-branch instruction in decode.
- branch_ne  in  1  branch condition select: 0 = taken when zero=1 (beq), 1 = taken when zero=0 (bne).
- zero  in  1  ALU zero flag.
- branch_address  in  WIDTH  branch target.
- jump  in  1  unconditional jump.
- jump_address  in  WIDTH  jump target.
- call  in  1  with jump, push pc_plus4 onto the RAS (jal).
- ret  in  1  pop the RAS top into the PC (jr $ra).
- pc_out  out  WIDTH  current PC (registered).
- pc_plus4  out  WIDTH  combinational pc_out + 4, modulo 2^WIDTH.
- ras_count  out  $clog2(RAS_DEPTH)+1  number of valid RAS entries (registered).
- ras_empty  out  1  ras_count == 0.
- ras_full  out  1  ras_count == RAS_DEPTH.
- ras_underflow  out  1  sticky flag, set when ret is executed on an empty RAS.

Behaviour:
- Reset (asynchronous, takes effect immediately on assertion, independent of clk):
  - pc_out = RESET_VECTOR.
  - ras_count = 0, RAS pointer = 0, all entries = 0.
  - ras_underflow = 0.
  - Reset asserted mid-operation discards any pending call/ret.
- Latency:
  - Next-PC selection is combinational.
  - pc_out takes the selected value on the next rising clk edge, so a control input applied in cycle N is visible on pc_out in cycle N+1.
- Target alignment: bits [1:0] of branch_address, jump_address and popped RAS values are forced to 0 before loading.
- Branch taken: branch & (branch_ne ? ~zero : zero).
- Next-PC priority, evaluated when stall=0:
  1. ret: pop.
     - If ras_count>0: PC = top entry, ras_count decrements.
     - If the RAS is empty: PC = pc_plus4, ras_underflow is set to 1, ras_count stays 0.
  2. jump: PC = jump_address.
     - If call=1, pc_plus4 is pushed in the same edge.
  3. branch taken: PC = branch_address.
  4. Otherwise: PC = pc_plus4.
- call without jump is ignored.
- ret together with jump/call: ret wins; no push and no jump.
- RAS push when full (overflow): the circular buffer overwrites the oldest entry and ras_count stays at RAS_DEPTH. No error flag is raised; deep recursion degrades to mispredicted returns only.
- RAS storage: circular array with a top pointer.
  - Push writes at pointer+1 and then advances the pointer, with wrap-around modulo RAS_DEPTH.
  - Pop reads at the pointer and then decrements the pointer, with wrap-around.
- stall=1: pc_out, RAS contents, pointer, ras_count and ras_underflow all hold, regardless of the other inputs.
- Wrap-around: PC at 2^WIDTH-4 with no redirect goes to 0.
- ras_underflow is cleared only by reset.

Test Plan (WIDTH=32, RESET_VECTOR=0x00400000, RAS_DEPTH=4):
- Reset, then 3 idle clocks: pc_out = 0x00400000 during reset, then 0x00400004, 0x00400008, 0x0040000C. Asynchronous reset asserted between edges returns pc_out to 0x00400000 immediately.
- Branch conditions:
  - branch=1, branch_ne=0, zero=0, target 0x10 → pc_out = pc+4.
  - zero=1 → pc_out = 0x10.
  - branch_ne=1, zero=0, target 0x20 → pc_out = 0x20.
  - branch_address=0x23 → pc_out = 0x20 (alignment).
- At PC 0x100, jump=1, call=1, jump_address=0x800 → pc_out = 0x800, ras_count = 1. Then ret=1 → pc_out = 0x104, ras_count = 0, ras_empty = 1.
- Five nested calls from PCs 0x100, 0x200, 0x300, 0x400, 0x500:
  - After the calls: ras_full = 1, ras_count = 4.
  - Four rets return 0x504, 0x404, 0x304, 0x204.
  - A fifth ret → pc_out = pc+4, ras_underflow = 1 (sticky).
- stall=1 for 3 cycles with jump=1, ret=1 and call asserted → pc_out, ras_count and flags unchanged. On stall release, the pending jump executes next edge.
- Simultaneous ret=1, jump=1, call=1 with RAS holding 0x204 → pc_out = 0x204, ras_count decrements, no push. PC at 0xFFFFFFFC, no control → pc_out = 0x00000000.
